// File: rtl/mem_arbiter.sv
// Arbitrates the single physical memory port between the I-side and D-side caches.
// Default: D-side priority with an I-side starvation guard; MEM_ARB_RR_EN selects round-robin.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned LINE_W     = 128,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

  state_e state_q, state_d;
  logic   d_req;

  assign d_req = d_read | d_write;

`ifdef MEM_ARB_RR_EN
  // 1 means the D-side held the most recent completed grant.
  logic last_grant_q, last_grant_d;
`else
  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);
  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    i_rdata      = '0;
    d_resp       = 1'b0;
    d_rdata      = '0;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`else
    starve_cnt_d = starve_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef MEM_ARB_RR_EN
        if (d_req && i_read) begin
          state_d = last_grant_q ? StServeI : StServeD;
        end else if (d_req) begin
          state_d = StServeD;
        end else if (i_read) begin
          state_d = StServeI;
        end
`else
        if (d_req && !(i_read && (starve_cnt_q == StarveMax))) begin
          state_d = StServeD;
        end else if (i_read) begin
          state_d = StServeI;
        end
`endif
      end
      StServeI: begin
        pmem_read    = 1'b1;
        pmem_address = i_address;
        if (pmem_resp) begin
          i_resp  = 1'b1;
          i_rdata = pmem_rdata;
          state_d = StIdle;
`ifdef MEM_ARB_RR_EN
          last_grant_d = 1'b0;
`else
          starve_cnt_d = '0;
`endif
        end
      end
      StServeD: begin
        pmem_address = d_address;
        // A simultaneous read and write is illegal; the write takes the port.
        if (d_write) begin
          pmem_write = 1'b1;
          pmem_wdata = d_wdata;
        end else begin
          pmem_read = 1'b1;
        end
        if (pmem_resp) begin
          d_resp  = 1'b1;
          d_rdata = pmem_rdata;
          state_d = StIdle;
`ifdef MEM_ARB_RR_EN
          last_grant_d = 1'b1;
`else
          if (!i_read) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q != StarveMax) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= 1'b0;
`else
      starve_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: transaction-level grant predictor plus a memory scoreboard.
module tb_mem_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned LW = 128;
  localparam int unsigned SM = 4;

  logic          clk;
  logic          rst_n;
  logic          i_read, i_resp, d_read, d_write, d_resp;
  logic          pmem_read, pmem_write, pmem_resp;
  logic [AW-1:0] i_address, d_address, pmem_address;
  logic [LW-1:0] i_rdata, d_rdata, d_wdata, pmem_wdata, pmem_rdata;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Environment knobs.
  int i_left = 0, d_left = 0, i_rate = 0, d_rate = 0;
  int lat_min = 0, lat_max = 3, spur_rate = 0;
  bit i_done = 0, d_done = 0, rsp_active = 0;
  int rsp_cnt = 0;

  logic [LW-1:0] phys_mem[int];
  logic [LW-1:0] ref_mem[int];

  // Reference: current owner of the port (0 none, 1 I, 2 D), D grants that passed a waiting I.
  int  m_gnt = 0;
  int  m_d_run = 0;
  bit  m_last_d = 0;
  byte glog[$];

  function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
    return {8{a ^ 16'h5a5a}};
  endfunction

  function automatic logic [LW-1:0] phys_rd(input logic [AW-1:0] a);
    return phys_mem.exists(int'(a)) ? phys_mem[int'(a)] : init_line(a);
  endfunction

  function automatic logic [LW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_line(a);
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return AW'(16'h1000 + 16'($urandom_range(0, 7)) * 16'h10);
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [LW-1:0] pack_log();
    logic [LW-1:0] r = '0;
    foreach (glog[k]) r = {r[LW-9:0], glog[k]};
    return r;
  endfunction

  function automatic logic [LW-1:0] pack_str(input string s);
    logic [LW-1:0] r = '0;
    for (int k = 0; k < s.len(); k++) r = {r[LW-9:0], s[k]};
    return r;
  endfunction

  task automatic drive_req();
    if (!rst_n) begin
      i_read = 0; d_read = 0; d_write = 0;
    end else begin
      if (!i_read || i_done) begin
        i_read = 0;
        if (i_left > 0 && $urandom_range(0, 99) < i_rate) begin
          i_read = 1; i_address = rand_addr(); i_left--;
        end
      end
      if (!(d_read || d_write) || d_done) begin
        d_read = 0; d_write = 0;
        if (d_left > 0 && $urandom_range(0, 99) < d_rate) begin
          int op = $urandom_range(0, 9);
          d_address = rand_addr(); d_wdata = rand_line();
          d_write = (op <= 4);
          d_read  = (op == 0) || (op > 4);
          d_left--;
        end
      end
    end
    i_done = 0; d_done = 0;
  endtask

  task automatic drive_mem();
    pmem_resp = 0; pmem_rdata = '0;
    if (!rst_n) begin
      rsp_active = 0;
    end else if (pmem_read || pmem_write) begin
      if (!rsp_active) begin
        rsp_active = 1; rsp_cnt = $urandom_range(lat_min, lat_max);
      end
      if (rsp_cnt == 0) begin
        pmem_resp = 1; rsp_active = 0;
        if (pmem_write) begin
          phys_mem[int'(pmem_address)] = pmem_wdata;
          pmem_rdata = rand_line();
        end else begin
          pmem_rdata = phys_rd(pmem_address);
        end
      end else begin
        rsp_cnt--;
      end
    end else begin
      rsp_active = 0;
      if ($urandom_range(0, 99) < spur_rate) begin
        pmem_resp = 1; pmem_rdata = rand_line();
      end
    end
  endtask

  task automatic check_and_predict();
    logic          e_pr = 0, e_pw = 0, e_ir = 0, e_dr = 0;
    logic [AW-1:0] e_addr = '0;
    logic [LW-1:0] e_wd = '0, e_id = '0, e_dd = '0;
    bit            dreq = d_read || d_write;
    if (m_gnt == 1) begin
      e_pr = 1; e_addr = i_address; e_ir = pmem_resp;
      if (pmem_resp) e_id = ref_rd(i_address);
    end else if (m_gnt == 2) begin
      e_pw = d_write; e_pr = !d_write; e_addr = d_address; e_dr = pmem_resp;
      if (d_write) e_wd = d_wdata;
      if (pmem_resp) e_dd = d_write ? pmem_rdata : ref_rd(d_address);
    end
    check("pmem_read", pmem_read, e_pr);
    check("pmem_write", pmem_write, e_pw);
    check("pmem_address", pmem_address, e_addr);
    check("pmem_wdata", pmem_wdata, e_wd);
    check("i_resp", i_resp, e_ir);
    check("i_rdata", i_rdata, e_id);
    check("d_resp", d_resp, e_dr);
    check("d_rdata", d_rdata, e_dd);
    i_done = i_resp; d_done = d_resp;
    if (!rst_n) begin
      m_gnt = 0; m_d_run = 0; m_last_d = 0;
    end else if (m_gnt == 0) begin
`ifdef MEM_ARB_RR_EN
      if (dreq && i_read) m_gnt = m_last_d ? 1 : 2;
      else if (dreq) m_gnt = 2;
      else if (i_read) m_gnt = 1;
`else
      if (dreq && !(i_read && m_d_run >= SM)) m_gnt = 2;
      else if (i_read) m_gnt = 1;
`endif
      if (m_gnt == 1) glog.push_back(8'h49);
      else if (m_gnt == 2) glog.push_back(8'h44);
    end else if (pmem_resp) begin
      if (m_gnt == 1) begin
        m_d_run = 0; m_last_d = 0;
      end else begin
        if (d_write) ref_mem[int'(d_address)] = d_wdata;
        m_d_run = !i_read ? 0 : (m_d_run < SM ? m_d_run + 1 : SM);
        m_last_d = 1;
      end
      m_gnt = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1 drive_req();
    #1 drive_mem();
    @(negedge clk);
    check_and_predict();
  endtask

  task automatic run_until_quiet(input int budget);
    bit quiet = 0;
    for (int c = 0; c < budget && !quiet; c++) begin
      step();
      quiet = (i_left == 0) && (d_left == 0) && !i_read && !d_read && !d_write && (m_gnt == 0);
    end
    check("quiet", quiet, 1);
  endtask

  initial begin
    string exp_order;
    rst_n = 0; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
    repeat (3) step();
    rst_n = 1;

    // Both sides request together; D goes first, then the guard (or alternation) decides.
    glog.delete();
    i_rate = 100; d_rate = 100; d_left = 6;
`ifdef MEM_ARB_RR_EN
    i_left = 6; exp_order = "DIDIDIDIDIDI";
`else
    i_left = 1; exp_order = "DDDDIDD";
`endif
    run_until_quiet(300);
    check("grant_order", pack_log(), pack_str(exp_order));

    // Memory responses while idle must be swallowed.
    spur_rate = 100;
    repeat (6) step();
    spur_rate = 0;

    // Abandon a D read two cycles into service.
    lat_min = 8; lat_max = 8; d_left = 1; i_left = 0;
    for (int c = 0; c < 20 && m_gnt != 2; c++) step();
    check("reached_serve_d", m_gnt, 2);
    repeat (2) step();
    rst_n = 0;
    #1;
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_pmem_address", pmem_address, 0);
    check("rst_d_resp", d_resp, 0);
    d_read = 0; d_write = 0; d_left = 0; rsp_active = 0;
    m_gnt = 0; m_d_run = 0; m_last_d = 0;
    repeat (2) step();
    rst_n = 1;
    lat_min = 0; lat_max = 3;

    glog.delete();
    i_left = 1;
    run_until_quiet(100);
    check("fresh_after_reset", pack_log(), pack_str("I"));

    // Mixed random traffic.
    i_left = 150; d_left = 150; i_rate = 30; d_rate = 50; spur_rate = 15;
    run_until_quiet(20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single physical memory port between the instruction-fetch side (mem1, I-side) and the data-access side (mem2, D-side) of the pipelined LC-3b core.
- Sits between the two caches and main memory.
- Grants one requester at a time and holds the grant until the memory responds.
- Default policy: D-side priority, with a starvation guard so instruction fetch always makes progress.

Parameters:
- ADDR_W, 16, physical address width.
- LINE_W, 128, cache line (data) width.
- STARVE_MAX, 4, consecutive D-side grants allowed while the I-side waits, before the I-side is forced.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_read  in  1  I-side read request, held until i_resp.
- i_address  in  ADDR_W  I-side line address.
- i_rdata  out  LINE_W  I-side read data.
- i_resp  out  1  I-side completion pulse.
- d_read  in  1  D-side read request, held until d_resp.
- d_write  in  1  D-side write request, held until d_resp.
- d_address  in  ADDR_W  D-side line address.
- d_wdata  in  LINE_W  D-side write data.
- d_rdata  out  LINE_W  D-side read data.
- d_resp  out  1  D-side completion pulse.
- pmem_read  out  1  physical memory read strobe.
- pmem_write  out  1  physical memory write strobe.
- pmem_address  out  ADDR_W  physical address.
- pmem_wdata  out  LINE_W  physical write data.
- pmem_rdata  in  LINE_W  physical read data.
- pmem_resp  in  1  physical memory completion, one cycle.

Behaviour:
- States are IDLE, SERVE_I and SERVE_D. The state register and the starvation counter starve_cnt (clog2(STARVE_MAX+1) bits) are the only storage.
- Reset (rst_n=0, asynchronous): state goes to IDLE and starve_cnt to 0. All outputs are 0 immediately: pmem_read, pmem_write, pmem_address, pmem_wdata, i_resp, d_resp, i_rdata, d_rdata.
- Reset asserted mid-transaction abandons it. No resp is ever issued for that transaction.
- IDLE:
  - Outputs are all 0.
  - On the next edge: if a D request is present and not forced, go to SERVE_D; else if i_read, go to SERVE_I; else stay.
  - "Forced" means i_read=1 and starve_cnt==STARVE_MAX. In that case go to SERVE_I even if a D request is present.
- SERVE_I:
  - pmem_read=1 and pmem_address=i_address, both combinational from the live requester inputs.
  - pmem_write=0 and pmem_wdata=0.
  - On pmem_resp=1: i_resp=1 and i_rdata=pmem_rdata in the same cycle. Next edge returns to IDLE and clears starve_cnt.
- SERVE_D:
  - pmem_address=d_address.
  - If d_write=1: pmem_write=1 and pmem_wdata=d_wdata. d_write=1 with d_read=1 is illegal; write wins and the read is ignored.
  - Else: pmem_read=1.
  - On pmem_resp: d_resp=1 and d_rdata=pmem_rdata in the same cycle. Next edge goes to IDLE.
  - starve_cnt increments, saturating at STARVE_MAX, only if i_read was 1 on that completing edge. Otherwise it clears.
- Outside a matching grant, i_rdata and d_rdata are 0.
- Latency:
  - A request seen in IDLE at edge N has pmem strobes asserted from cycle N+1.
  - resp is combinational with pmem_resp.
  - There is one mandatory IDLE cycle between transactions, so a requester deasserts before it is resampled.
- pmem_resp while in IDLE is ignored; no resp is generated.
- A requester dropping its request before resp is illegal. The arbiter stays in its SERVE state until pmem_resp regardless.
- Both resp outputs are never high in the same cycle.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin policy.
  - A 1-bit last_grant register (reset 0 = I) replaces starve_cnt.
  - When both sides request in IDLE, the side not in last_grant wins.
  - last_grant updates on each completing edge.
  - STARVE_MAX is unused.
- Undefined: D-priority plus starvation guard, exactly as in Behaviour.

Test Plan:
- Single I read: i_read=1, i_address=0x1230, memory resp after 3 cycles with rdata=0xA5..A5 -> pmem_read=1 and pmem_address=0x1230 from cycle 1; i_resp=1 and i_rdata=0xA5..A5 in exactly one cycle; then IDLE with pmem strobes 0.
- Simultaneous requests: i_read=1, d_write=1, d_address=0x4000, d_wdata=0x0F..0F, all in the same cycle -> D served first (pmem_write=1, pmem_address=0x4000); I served after d_resp and one IDLE cycle.
- Starvation guard: i_read held, D issues 6 back-to-back reads, STARVE_MAX=4 -> 4 D grants, then the I grant, then the remaining D grants; starve_cnt returns to 0 after i_resp.
- Reset mid-operation: rst_n=0 two cycles into SERVE_D -> pmem_read/pmem_write fall to 0 asynchronously before the next edge; no d_resp; after release, a fresh request is served normally.
- Spurious resp and illegal op: pmem_resp=1 in IDLE -> no i_resp or d_resp. d_read=1 with d_write=1 -> pmem_write=1 and pmem_read=0.
- MEM_ARB_RR_EN defined, both sides requesting continuously -> grants strictly alternate D, I, D, I… starting with D (last_grant reset = I).
